// File: rtl/divider_pkg.sv
// Shared divider definitions: FSM states, iteration count, ALU op codes
// and an operand magnitude helper used when a divide is accepted.
package divider_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Two's-complement magnitude in signed mode, raw value otherwise.
  function automatic logic [31:0] abs32(input logic sgn,
                                        input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: 33-bit conditional subtract.
// rem_i: shifted partial remainder, divisor_i: divisor magnitude,
// rem_o: next partial remainder, q_o: quotient bit produced.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] diff;

  assign diff  = rem_i - {1'b0, divisor_i};
  assign q_o   = ~diff[32];
  assign rem_o = q_o ? diff[31:0] : rem_i[31:0];

endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Ports: clk, rst (async high), signed_div_i, opdata1_i, opdata2_i,
// start_i, annul_i, result_o {rem,quo}, ready_o pulse, busy_o.
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // acc[64:32] shifted remainder, acc[31:0] dividend bits / quotient
  logic [64:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        sg_q, sg_d;
  logic [63:0] res_q, res_d;

  logic [31:0] step_rem;
  logic        step_q;

  div_step u_step (
    .rem_i     (acc_q[64:32]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    logic [31:0] quo;
    logic [31:0] rem;
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    sg_d    = sg_q;
    res_d   = res_q;
    quo     = '0;
    rem     = '0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          s1_d  = opdata1_i[31];
          s2_d  = opdata2_i[31];
          sg_d  = signed_div_i;
          dvs_d = abs32(signed_div_i, opdata2_i);
          acc_d = {32'd0, abs32(signed_div_i, opdata1_i), 1'b0};
          cnt_d = '0;
          state_d = (opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_END;
          res_d   = 64'd0;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = {step_rem, acc_q[31:0], step_q};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_CYCLES - 1)) begin
            state_d = DIV_END;
            quo = acc_d[31:0];
            rem = acc_d[64:33];
            if (sg_q && (s1_q ^ s2_q)) quo = 32'd0 - quo;
            if (sg_q && s1_q)          rem = 32'd0 - rem;
            res_d = {rem, quo};
          end
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      sg_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sg_q    <= sg_d;
      res_q   <= res_d;
    end
  end

  assign result_o = res_q;
  assign ready_o  = (state_q == DIV_END);
  assign busy_o   = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: issued vectors push expected results and
// ready cycles into a queue; a negedge monitor pops and compares.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  divider dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  exp_t sb[$];
  int   ncyc = 0;
  int   nchk = 0;
  int   errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ready_o) begin
      if (sb.size() == 0) begin
        nchk++;
        errs++;
        $display("FAIL spurious_ready: got result %h at cycle %0d, none expected",
                 result_o, ncyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("ready_cycle", 64'(ncyc), 64'(e.cyc));
      end
    end
    ncyc <= ncyc + 1;
  end

  task automatic issue(input bit rel, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] r,
                       input bit push);
    exp_t e;
    @(negedge clk);
    #1;
    if (rel) rst = 1'b0;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) begin
      e.res = r;
      e.cyc = ncyc + ((b == 32'd0) ? 1 : 32);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      nchk++;
      errs++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy_o, n);
    end
  endtask

  vec_t vt[10];

  initial begin
    vt = '{
      '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD},
      '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD},
      '{1'b0, 32'd123,       32'd0,         64'h0},
      '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000},
      '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E},
      '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_7FFF_FFFF},
      '{1'b0, 32'd5,         32'd10,        64'h0000_0005_0000_0000},
      '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000},
      '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'h0000_0001_0000_0001},
      '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC}
    };

    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'h0);
    chk("reset_ready", 64'(ready_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);

    // first edge after reset release accepts; mid-ON start is ignored
    issue(1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    signed_div_i = 1'b1;
    opdata1_i    = 32'd55;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      issue(1'b0, vt[i].sg, vt[i].a, vt[i].b, vt[i].r, 1'b1);
      wait_idle();
    end

    // back-to-back
    issue(1'b0, 1'b0, 32'd1, 32'd1, {32'd0, 32'd1}, 1'b1);
    wait_idle();
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b1);
    wait_idle();

    // annul at count 10
    issue(1'b0, 1'b0, 32'd1000, 32'd3, 64'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'h0);
    chk("annul_ready", 64'(ready_o), 64'h0);
    chk("annul_hold", result_o, {32'd0, 32'hFFFF_FFFF});

    // annul in BYZERO
    issue(1'b0, 1'b0, 32'd9, 32'd0, 64'h0, 1'b0);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    chk("annul_bz_busy", 64'(busy_o), 64'h0);
    chk("annul_bz_hold", result_o, {32'd0, 32'hFFFF_FFFF});

    issue(1'b0, 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b1);
    wait_idle();

    // reset mid-ON
    issue(1'b0, 1'b0, 32'd50, 32'd3, 64'h0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_result", result_o, 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 1'b1);
    wait_idle();

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (40) @(negedge clk);
      chk("drain", 64'(sb.size()), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, errs);
    $finish;
  end

endmodule
